contador_param: RTL and testbench

CONTADOR_PARAM -- requirements
Module: contador_param

---
 rtl/contador_pkg.sv | 21 ++
 rtl/contador_ch.sv | 40 ++++
 rtl/contador_param.sv | 141 ++++++++++++++
 tb/tb_contador_param.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared definitions for the multi-channel pop counter: read FSM encoding and defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package contador_pkg;

  // Default channel count and per-channel counter width
  localparam int DEF_NUM_CH = 4;
  localparam int DEF_CW     = 5;

  // Read sequencer states
  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // Width of a channel index; never narrower than one bit
  function automatic int sel_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/contador_ch.sv
// One channel: CW-bit pop counter (wrap or saturate) with sticky overflow flag.
// Latency: count/ovf update on the rising edge after inc/clr.
// Backpressure: none; every inc is counted.
module contador_ch
  import contador_pkg::*;
#(
  parameter int CW = DEF_CW
) (
  input  logic          clk,
  input  logic          reset_L,
  input  logic          inc,
  input  logic          clr,
  input  logic          sat,
  output logic [CW-1:0] count,
  output logic          ovf
);

  logic at_max;
  logic ovf_evt;

  assign at_max  = &count;
  assign ovf_evt = inc & at_max;

  // Counter and sticky flag; a clear restarts from this cycle's pop and keeps a same-cycle overflow
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      count <= '0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= inc ? CW'(1) : '0;
      ovf   <= ovf_evt;
    end else begin
      if (inc && !(at_max && sat)) begin
        count <= count + 1'b1;
      end
      ovf <= ovf | ovf_evt;
    end
  end

endmodule

// File: rtl/contador_param.sv
// NUM_CH pop counters with a registered single/burst read port and optional clear-on-read.
// Latency: response registered at the edge sampling the request; burst reads one channel per cycle.
// Backpressure: requests are dropped (not queued) while a burst is running.
module contador_param
  import contador_pkg::*;
#(
  parameter  int NUM_CH = DEF_NUM_CH,
  parameter  int CW     = DEF_CW,
  localparam int SEL_W  = sel_width(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic [NUM_CH-1:0] pop,
  input  logic              request,
  input  logic [SEL_W-1:0]  sel,
  input  logic              burst,
  input  logic              clr_on_rd,
  input  logic              sat_mode,
  output logic [CW-1:0]     contador,
  output logic [SEL_W-1:0]  ch_id,
  output logic              ovf,
  output logic              valid,
  output logic              busy
);

  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

  state_t             state;
  state_t             state_nxt;
  logic [SEL_W-1:0]   ptr;
  logic               burst_go;
  logic               rd_en;
  logic [SEL_W-1:0]   rd_idx;
  logic [NUM_CH-1:0]  clr_vec;
  logic [CW-1:0]      cnt_arr [NUM_CH];
  logic [NUM_CH-1:0]  ovf_vec;
  logic [CW-1:0]      mux_cnt;
  logic               mux_ovf;

  // A burst starting at the last channel is just a single read, so it never enters BURST
  assign burst_go = (state == IDLE) & request & burst & (sel < LAST_CH);

  genvar g;
  generate
    for (g = 0; g < NUM_CH; g++) begin : g_ch
      contador_ch #(.CW(CW)) u_ch (
        .clk     (clk),
        .reset_L (reset_L),
        .inc     (pop[g]),
        .clr     (clr_vec[g]),
        .sat     (sat_mode),
        .count   (cnt_arr[g]),
        .ovf     (ovf_vec[g])
      );
    end
  endgenerate

  // FSM state register
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next state: leave BURST once the last channel has been read
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (burst_go) state_nxt = BURST;
      BURST:   if (ptr == LAST_CH) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: which channel is read this edge, if any
  always_comb begin
    rd_en  = 1'b0;
    rd_idx = sel;
    case (state)
      IDLE: begin
        rd_en  = request;
        rd_idx = sel;
      end
      BURST: begin
        rd_en  = 1'b1;
        rd_idx = ptr;
      end
      default: begin
        rd_en  = 1'b0;
        rd_idx = sel;
      end
    endcase
  end

  // Channel mux and clear decode; an out-of-range index selects nothing and reads as zero
  always_comb begin
    mux_cnt = '0;
    mux_ovf = 1'b0;
    clr_vec = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (rd_idx == SEL_W'(i)) begin
        mux_cnt    = cnt_arr[i];
        mux_ovf    = ovf_vec[i];
        clr_vec[i] = rd_en & clr_on_rd;
      end
    end
  end

  // Burst pointer: next channel to read while in BURST
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ptr <= '0;
    end else if (burst_go) begin
      ptr <= sel + 1'b1;
    end else if (state == BURST) begin
      ptr <= ptr + 1'b1;
    end
  end

  // Response registers: load on a read, otherwise hold data and drop valid
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      contador <= '0;
      ch_id    <= '0;
      ovf      <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      valid <= rd_en;
      busy  <= (state == BURST);
      if (rd_en) begin
        contador <= mux_cnt;
        ch_id    <= rd_idx;
        ovf      <= mux_ovf;
      end
    end
  end

endmodule

// File: tb/tb_contador_param.sv
// Self-checking bench for contador_param: a 4-channel/3-bit instance and a 3-channel instance.
// Latency: checks one cycle-step after each rising edge.
// Backpressure: n/a.
module tb_contador_param;

  logic       clk = 1'b0;
  logic       reset_L;

  logic [3:0] pop_a;
  logic       req_a, burst_a, clr_a, sat_a;
  logic [1:0] sel_a;
  logic [2:0] cnt_a;
  logic [1:0] ch_a;
  logic       ovf_a, valid_a, busy_a;

  logic [2:0] pop_b;
  logic       req_b, burst_b, clr_b, sat_b;
  logic [1:0] sel_b;
  logic [2:0] cnt_b;
  logic [1:0] ch_b;
  logic       ovf_b, valid_b, busy_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  contador_param #(.NUM_CH(4), .CW(3)) dut_a (
    .clk(clk), .reset_L(reset_L), .pop(pop_a), .request(req_a), .sel(sel_a),
    .burst(burst_a), .clr_on_rd(clr_a), .sat_mode(sat_a),
    .contador(cnt_a), .ch_id(ch_a), .ovf(ovf_a), .valid(valid_a), .busy(busy_a)
  );

  contador_param #(.NUM_CH(3), .CW(3)) dut_b (
    .clk(clk), .reset_L(reset_L), .pop(pop_b), .request(req_b), .sel(sel_b),
    .burst(burst_b), .clr_on_rd(clr_b), .sat_mode(sat_b),
    .contador(cnt_b), .ch_id(ch_b), .ovf(ovf_b), .valid(valid_b), .busy(busy_b)
  );

  typedef struct {
    int         reps;
    logic [3:0] pop;
    logic       req;
    logic [1:0] sel;
    logic       bst;
    logic       clr;
    logic       sat;
    logic       e_valid;
    logic [2:0] e_cnt;
    logic [1:0] e_ch;
    logic       e_ovf;
    logic       e_busy;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input int reps, input logic [3:0] pop, input logic req,
                              input logic [1:0] sel, input logic bst, input logic clr,
                              input logic sat, input logic ev, input logic [2:0] ec,
                              input logic [1:0] ech, input logic eo, input logic eb);
    vec_t v;
    v.reps = reps; v.pop = pop; v.req = req; v.sel = sel; v.bst = bst; v.clr = clr;
    v.sat = sat; v.e_valid = ev; v.e_cnt = ec; v.e_ch = ech; v.e_ovf = eo; v.e_busy = eb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input logic ev, input logic [2:0] ec,
                       input logic [1:0] ech, input logic eo, input logic eb);
    chk({tag, ".valid"},    32'(valid_a), 32'(ev));
    chk({tag, ".contador"}, 32'(cnt_a),   32'(ec));
    chk({tag, ".ch_id"},    32'(ch_a),    32'(ech));
    chk({tag, ".ovf"},      32'(ovf_a),   32'(eo));
    chk({tag, ".busy"},     32'(busy_a),  32'(eb));
  endtask

  task automatic chk_b(input string tag, input logic ev, input logic [2:0] ec,
                       input logic [1:0] ech, input logic eo, input logic eb);
    chk({tag, ".valid"},    32'(valid_b), 32'(ev));
    chk({tag, ".contador"}, 32'(cnt_b),   32'(ec));
    chk({tag, ".ch_id"},    32'(ch_b),    32'(ech));
    chk({tag, ".ovf"},      32'(ovf_b),   32'(eo));
    chk({tag, ".busy"},     32'(busy_b),  32'(eb));
  endtask

  // Drive instance A for one cycle, then step to just after the rising edge
  task automatic cyc_a(input logic [3:0] p, input logic r, input logic [1:0] s,
                       input logic b, input logic c, input logic sm);
    pop_a = p; req_a = r; sel_a = s; burst_a = b; clr_a = c; sat_a = sm;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input logic [2:0] p, input logic r, input logic [1:0] s,
                       input logic b, input logic c);
    pop_b = p; req_b = r; sel_b = s; burst_b = b; clr_b = c; sat_b = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //           reps pop    rq sel bs cl sm  ev ec ech eo eb
    vecs[0]  = mk(9,  4'b0100, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[1]  = mk(1,  4'b0000, 1, 2, 0, 0, 0,  1, 1, 2, 1, 0);
    vecs[2]  = mk(1,  4'b0000, 0, 0, 0, 0, 0,  0, 1, 2, 1, 0);
    vecs[3]  = mk(1,  4'b0000, 1, 2, 0, 0, 0,  1, 1, 2, 1, 0);
    vecs[4]  = mk(10, 4'b0001, 0, 0, 0, 0, 1,  0, 1, 2, 1, 0);
    vecs[5]  = mk(1,  4'b0000, 1, 0, 0, 1, 1,  1, 7, 0, 1, 0);
    vecs[6]  = mk(1,  4'b0000, 1, 0, 0, 1, 1,  1, 0, 0, 0, 0);
    vecs[7]  = mk(5,  4'b0010, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0);
    vecs[8]  = mk(1,  4'b0010, 1, 1, 0, 1, 0,  1, 5, 1, 0, 0);
    vecs[9]  = mk(1,  4'b0000, 1, 1, 0, 0, 0,  1, 1, 1, 0, 0);
    vecs[10] = mk(7,  4'b1000, 0, 0, 0, 0, 0,  0, 1, 1, 0, 0);
    vecs[11] = mk(1,  4'b1000, 1, 3, 0, 1, 0,  1, 7, 3, 0, 0);
    vecs[12] = mk(1,  4'b0000, 1, 3, 0, 0, 0,  1, 1, 3, 1, 0);
    vecs[13] = mk(1,  4'b0000, 1, 3, 1, 0, 0,  1, 1, 3, 1, 0);
    vecs[14] = mk(1,  4'b0000, 0, 0, 0, 0, 0,  0, 1, 3, 1, 0);
    vecs[15] = mk(1,  4'b0000, 1, 2, 0, 0, 0,  1, 1, 2, 1, 0);

    reset_L = 1'b0;
    pop_a = '0; req_a = 0; sel_a = '0; burst_a = 0; clr_a = 0; sat_a = 0;
    pop_b = '0; req_b = 0; sel_b = '0; burst_b = 0; clr_b = 0; sat_b = 0;
    #2;
    chk_a("rst_a", 0, 0, 0, 0, 0);
    chk_b("rst_b", 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_L = 1'b1;

    // Table: wrap, saturate, clear-on-read, same-cycle pop, burst at last channel
    for (int i = 0; i < 16; i++) begin
      for (int r = 0; r < vecs[i].reps; r++) begin
        cyc_a(vecs[i].pop, vecs[i].req, vecs[i].sel, vecs[i].bst, vecs[i].clr, vecs[i].sat);
      end
      chk_a($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_cnt, vecs[i].e_ch,
            vecs[i].e_ovf, vecs[i].e_busy);
    end

    // Fresh reset, then counts 1,2,3,4 on ch0..ch3
    cyc_a(4'b0000, 0, 0, 0, 0, 0);
    reset_L = 1'b0;
    #1;
    chk_a("rst2", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_L = 1'b1;
    cyc_a(4'b1111, 0, 0, 0, 0, 0);
    cyc_a(4'b1110, 0, 0, 0, 0, 0);
    cyc_a(4'b1100, 0, 0, 0, 0, 0);
    cyc_a(4'b1000, 0, 0, 0, 0, 0);

    // Burst from ch1; a request during the burst is dropped
    cyc_a(4'b0000, 1, 1, 1, 0, 0);
    chk_a("bst_r1", 1, 2, 1, 0, 0);
    cyc_a(4'b0000, 1, 0, 0, 0, 0);
    chk_a("bst_r2", 1, 3, 2, 0, 1);
    cyc_a(4'b0000, 0, 0, 0, 0, 0);
    chk_a("bst_r3", 1, 4, 3, 0, 1);
    cyc_a(4'b0000, 0, 0, 0, 0, 0);
    chk_a("bst_end", 0, 4, 3, 0, 0);
    cyc_a(4'b0000, 1, 0, 0, 0, 0);
    chk_a("post_bst", 1, 1, 0, 0, 0);

    // Burst from ch0, reset asserted in its second cycle
    cyc_a(4'b0000, 1, 0, 1, 0, 0);
    chk_a("abort_r1", 1, 1, 0, 0, 0);
    cyc_a(4'b0000, 0, 0, 0, 0, 0);
    chk_a("abort_r2", 1, 2, 1, 0, 1);
    #1;
    reset_L = 1'b0;
    #1;
    chk_a("abort_rst", 0, 0, 0, 0, 0);
    @(negedge clk);
    reset_L = 1'b1;
    cyc_a(4'b1111, 0, 0, 0, 0, 0);
    chk_a("rel_0", 0, 0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      cyc_a(4'b0000, 0, 0, 0, 0, 0);
      chk_a($sformatf("rel_%0d", i), 0, 0, 0, 0, 0);
    end
    cyc_a(4'b0000, 1, 3, 0, 0, 0);
    chk_a("rel_rd3", 1, 1, 3, 0, 0);
    cyc_a(4'b0000, 1, 0, 0, 0, 0);
    chk_a("rel_rd0", 1, 1, 0, 0, 0);
    cyc_a(4'b0000, 0, 0, 0, 0, 0);

    // Three-channel instance: out-of-range reads and short bursts
    cyc_b(3'b111, 0, 0, 0, 0);
    cyc_b(3'b111, 0, 0, 0, 0);
    chk_b("b_idle", 0, 0, 0, 0, 0);
    cyc_b(3'b000, 1, 3, 0, 1);
    chk_b("b_oor", 1, 0, 3, 0, 0);
    cyc_b(3'b000, 1, 2, 0, 0);
    chk_b("b_rd2", 1, 2, 2, 0, 0);
    cyc_b(3'b000, 1, 3, 1, 0);
    chk_b("b_oor_bst", 1, 0, 3, 0, 0);
    cyc_b(3'b000, 0, 0, 0, 0);
    chk_b("b_oor_bst_end", 0, 0, 3, 0, 0);
    cyc_b(3'b000, 1, 1, 1, 0);
    chk_b("b_bst_r1", 1, 2, 1, 0, 0);
    cyc_b(3'b000, 0, 0, 0, 0);
    chk_b("b_bst_r2", 1, 2, 2, 0, 1);
    cyc_b(3'b000, 0, 0, 0, 0);
    chk_b("b_bst_end", 0, 2, 2, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
